fifo_word_packer: RTL and testbench

FIFO_WORD_PACKER -- requirements
Module: fifo_word_packer

---
 rtl/fifo_word_packer_pkg.sv | 17 +
 rtl/pack_idle_timer.sv | 29 ++
 rtl/fifo_word_packer.sv | 96 +++++++++
 tb/tb_fifo_word_packer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_word_packer_pkg.sv
// Shared types and helpers for the FIFO word packer.
// The optional idle auto-flush is enabled with FIFO_WORD_PACKER_TIMEOUT_EN.
package fifo_word_packer_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_e;

    // Idle timer width; wide enough for the largest legal TIMEOUT_CYCLES (255).
    localparam int TIMER_W = 8;

    function automatic int countWidth(input int pack);
        return $clog2(pack + 1);
    endfunction

endpackage

// File: rtl/pack_idle_timer.sv
// Counts consecutive idle cycles and flags the cycle on which LIMIT is reached.
// Only instantiated when FIFO_WORD_PACKER_TIMEOUT_EN is defined.
module pack_idle_timer
    import fifo_word_packer_pkg::*;
#(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic count_en_i,
    output logic expired_o
);

    logic [TIMER_W-1:0] count_q;

    // Expiry fires combinationally on the LIMIT-th idle cycle so the close happens on that edge.
    assign expired_o = count_en_i && (count_q == TIMER_W'(LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (!count_en_i || expired_o) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_word_packer.sv
// Packs PACK consecutive FIFO words into one wide beat, closing early on flush.
// Define FIFO_WORD_PACKER_TIMEOUT_EN to also close a partial beat after TIMEOUT_CYCLES idle cycles.
module fifo_word_packer
    import fifo_word_packer_pkg::*;
#(
    parameter int DWIDTH         = 32,
    parameter int PACK           = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                fifo_valid,
    input  logic [DWIDTH-1:0]                   fifo_data,
    output logic                                fifo_deque_en,
    input  logic                                flush,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [PACK*DWIDTH-1:0]              out_data,
    output logic [countWidth(PACK)-1:0]         out_count
);

    localparam int CW = countWidth(PACK);

    if (PACK < 2 || PACK > 16) begin : g_bad_pack
        $error("fifo_word_packer: PACK must be within 2..16");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("fifo_word_packer: TIMEOUT_CYCLES must be within 1..255");
    end

    pack_state_e         state_q;
    logic [CW-1:0]       fillCnt_q;
    logic [PACK*DWIDTH-1:0] lanes_q;
    logic                pop;
    logic [CW-1:0]       fillCnt_d;
    logic                timeoutHit;

    // In HOLD we only pop when the beat leaves, so the popped word can seed the next beat.
    assign fifo_deque_en = !rst && ((state_q == FILL) || out_ready);
    assign pop           = fifo_deque_en && fifo_valid;
    assign fillCnt_d     = fillCnt_q + CW'(pop);

    assign out_valid = (state_q == HOLD);
    assign out_count = out_valid ? fillCnt_q : '0;
    assign out_data  = lanes_q;

`ifdef FIFO_WORD_PACKER_TIMEOUT_EN
    logic idleCycle;

    assign idleCycle = (state_q == FILL) && (fillCnt_q != '0) && !pop;

    pack_idle_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk       (clk),
        .rst       (rst),
        .count_en_i(idleCycle),
        .expired_o (timeoutHit)
    );
`else
    assign timeoutHit = 1'b0;
`endif

    // Lanes are cleared whenever a beat leaves, which keeps lanes at or above out_count zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FILL;
            fillCnt_q <= '0;
            lanes_q   <= '0;
        end else begin
            case (state_q)
                FILL: begin
                    for (int i = 0; i < PACK; i++) begin
                        if (pop && (fillCnt_q == CW'(i))) begin
                            lanes_q[i*DWIDTH +: DWIDTH] <= fifo_data;
                        end
                    end
                    fillCnt_q <= fillCnt_d;
                    if ((fillCnt_d == CW'(PACK)) ||
                        ((flush || timeoutHit) && (fillCnt_d != '0))) begin
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        lanes_q   <= {{((PACK-1)*DWIDTH){1'b0}}, (pop ? fifo_data : {DWIDTH{1'b0}})};
                        fillCnt_q <= CW'(pop);
                        state_q   <= FILL;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed self-checking bench for fifo_word_packer (DWIDTH=32, PACK=4, TIMEOUT_CYCLES=16).
// Timeout expectations follow FIFO_WORD_PACKER_TIMEOUT_EN.
module tb_fifo_word_packer;

    localparam int DW = 32;
    localparam int PK = 4;
    localparam int TO = 16;
    localparam int CW = $clog2(PK + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             fifoValid;
    logic [DW-1:0]    fifoData;
    logic             fifoDequeEn;
    logic             flush;
    logic             outValid;
    logic             outReady;
    logic [PK*DW-1:0] outData;
    logic [CW-1:0]    outCount;

    logic [DW-1:0]    mem [0:63];
    int               wrIdx = 0;
    int               rdIdx = 0;
    logic             srcEn;

    int               cycle = 0;
    int               popCnt = 0;
    int               popCyc[$];
    logic [PK*DW-1:0] beatData[$];
    logic [CW-1:0]    beatCnt[$];

    int               checks = 0;
    int               errors = 0;

    fifo_word_packer #(
        .DWIDTH(DW),
        .PACK(PK),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_valid   (fifoValid),
        .fifo_data    (fifoData),
        .fifo_deque_en(fifoDequeEn),
        .flush        (flush),
        .out_valid    (outValid),
        .out_ready    (outReady),
        .out_data     (outData),
        .out_count    (outCount)
    );

    always #5 clk = ~clk;

    // Simple FIFO model: head word is combinational, read pointer advances on a real pop.
    assign fifoValid = srcEn && (rdIdx != wrIdx);
    assign fifoData  = mem[rdIdx % 64];

    always @(posedge clk) begin
        if (fifoDequeEn && fifoValid) rdIdx <= rdIdx + 1;
    end

    always @(negedge clk) begin
        cycle = cycle + 1;
        if (fifoDequeEn && fifoValid) begin
            popCnt = popCnt + 1;
            popCyc.push_back(cycle);
        end
        if (outValid && outReady) begin
            beatData.push_back(outData);
            beatCnt.push_back(outCount);
        end
    end

    task automatic checkOutput(input string tag, input logic [PK*DW-1:0] observed,
                               input logic [PK*DW-1:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [DW-1:0] word);
        mem[wrIdx % 64] = word;
        wrIdx++;
    endtask

    task automatic driveEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic waitNeg();
        @(negedge clk);
        #1;
    endtask

    task automatic waitPops(input int target, input string tag);
        int n = 0;
        while (popCnt < target && n < 50) begin
            waitNeg();
            n++;
        end
        checkOutput(tag, (popCnt >= target), 1);
    endtask

    task automatic waitValid(input string tag, output int n);
        n = 0;
        while (!outValid && n < 60) begin
            waitNeg();
            n++;
        end
        checkOutput(tag, outValid, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int p;
        int n;
        int b0;
        int pc0;
        logic seen;
        logic [PK*DW-1:0] exp;

        rst = 1'b1; srcEn = 1'b0; flush = 1'b0; outReady = 1'b0;
        repeat (3) waitNeg();
        checkOutput("rst_valid", outValid, 0);
        checkOutput("rst_count", outCount, 0);
        checkOutput("rst_data", outData, 0);
        checkOutput("rst_deque", fifoDequeEn, 0);
        driveEdge();
        rst = 1'b0;

        // Full beat and one-cycle latency after the 4th pop
        outReady = 1'b1;
        applyStimulus(32'h11); applyStimulus(32'h22);
        applyStimulus(32'h33); applyStimulus(32'h44);
        srcEn = 1'b1;
        b0 = beatData.size();
        waitPops(popCnt + 4, "full_pops");
        waitNeg();
        checkOutput("full_latency", outValid, 1);
        checkOutput("full_count", outCount, 4);
        checkOutput("full_data", outData, 128'h00000044_00000033_00000022_00000011);
        checkOutput("full_xfer", beatData.size(), b0 + 1);

        // Streaming: 12 words, no bubbles, three ordered beats
        driveEdge();
        b0  = beatData.size();
        pc0 = popCyc.size();
        p   = popCnt;
        for (int i = 0; i < 12; i++) applyStimulus(32'h100 + i);
        waitPops(p + 12, "stream_pops");
        n = 0;
        while (beatData.size() < b0 + 3 && n < 10) begin
            waitNeg();
            n++;
        end
        checkOutput("stream_beats", beatData.size(), b0 + 3);
        checkOutput("stream_nogap", popCyc[pc0 + 11] - popCyc[pc0], 11);
        for (int j = 0; j < 3; j++) begin
            for (int k = 0; k < PK; k++) exp[k*DW +: DW] = 32'h100 + 4*j + k;
            checkOutput($sformatf("stream_data%0d", j), beatData[b0 + j], exp);
            checkOutput($sformatf("stream_count%0d", j), beatCnt[b0 + j], 4);
        end

        // Flush of a partial beat, then flush with nothing collected
        driveEdge();
        outReady = 1'b0;
        p = popCnt;
        applyStimulus(32'hA); applyStimulus(32'hB);
        waitPops(p + 2, "flush_pops");
        driveEdge(); flush = 1'b1;
        driveEdge(); flush = 1'b0;
        waitNeg();
        checkOutput("flush_valid", outValid, 1);
        checkOutput("flush_count", outCount, 2);
        checkOutput("flush_data", outData, 128'h00000000_00000000_0000000B_0000000A);
        driveEdge(); outReady = 1'b1;
        driveEdge(); outReady = 1'b0; flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            waitNeg();
            checkOutput($sformatf("flush_empty%0d", i), outValid, 0);
        end
        driveEdge(); flush = 1'b0;

        // Backpressure: held beat is stable and nothing is popped
        for (int i = 1; i <= 7; i++) applyStimulus(32'h200 + i);
        waitValid("bp_valid", n);
        p = popCnt;
        for (int i = 0; i < 5; i++) begin
            waitNeg();
            checkOutput($sformatf("bp_hold%0d", i), outData, 128'h00000204_00000203_00000202_00000201);
            checkOutput($sformatf("bp_deque%0d", i), fifoDequeEn, 0);
        end
        checkOutput("bp_nopop", popCnt, p);
        driveEdge(); outReady = 1'b1;
        driveEdge(); outReady = 1'b0;
        checkOutput("bp_xfer", beatData[beatData.size() - 1], 128'h00000204_00000203_00000202_00000201);
        waitPops(p + 3, "bp_pops");
        driveEdge(); flush = 1'b1;
        driveEdge(); flush = 1'b0;
        waitNeg();
        checkOutput("bp_next_count", outCount, 3);
        checkOutput("bp_next_data", outData, 128'h00000000_00000207_00000206_00000205);
        driveEdge(); outReady = 1'b1;
        driveEdge(); outReady = 1'b0;

        // Idle timeout behaviour on a single word
        p = popCnt;
        applyStimulus(32'h77);
        waitPops(p + 1, "to_pop");
`ifdef FIFO_WORD_PACKER_TIMEOUT_EN
        waitValid("to_valid", n);
        checkOutput("to_delay", n, TO + 1);
`else
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            waitNeg();
            if (outValid) seen = 1'b1;
        end
        checkOutput("to_nobeat", seen, 0);
        driveEdge(); flush = 1'b1;
        driveEdge(); flush = 1'b0;
        waitNeg();
`endif
        checkOutput("to_count", outCount, 1);
        checkOutput("to_data", outData, 128'h77);
        driveEdge(); outReady = 1'b1;
        driveEdge(); outReady = 1'b0;

        // Reset in the middle of a fill discards the partial beat
        p = popCnt;
        applyStimulus(32'h301); applyStimulus(32'h302); applyStimulus(32'h303);
        waitPops(p + 3, "rm_pops");
        driveEdge(); rst = 1'b1;
        for (int i = 1; i <= 4; i++) applyStimulus(32'h400 + i);
        p = popCnt;
        repeat (2) waitNeg();
        checkOutput("rm_valid", outValid, 0);
        checkOutput("rm_count", outCount, 0);
        checkOutput("rm_data", outData, 0);
        checkOutput("rm_deque", fifoDequeEn, 0);
        checkOutput("rm_nopop", popCnt, p);
        driveEdge(); rst = 1'b0;
        waitValid("rm_beat_valid", n);
        checkOutput("rm_beat_count", outCount, 4);
        checkOutput("rm_beat_data", outData, 128'h00000404_00000403_00000402_00000401);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
